// File: rtl/decode_pkg.sv
// Shared decode constants: opcode encodings, inst_type bit positions,
// stage FSM states and the control_out width derived from the PC width.
package decode_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ILL1 = 3'b001;
    localparam logic [2:0] OP_ILL2 = 3'b010;
    localparam logic [2:0] OP_LDR  = 3'b011;
    localparam logic [2:0] OP_STR  = 3'b100;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int INST_LDR_BIT = 0;
    localparam int INST_STR_BIT = 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    // {opcode[2:0], pc, asel, bsel, loads, ALUop[1:0], shift[1:0], write, writenum[2:0]}
    function automatic int ctrl_w(input int pc_w);
        return pc_w + 14;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder: turns one 16-bit instruction and
// its PC into the control/operand bundle carried down the pipeline.
module decode_comb
    import decode_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int IMM_W = 16
) (
    input  logic [15:0]             ir,
    input  logic [PC_W-1:0]         pc,
    output logic [ctrl_w(PC_W)-1:0] control,
    output logic [2:0]              num_rm,
    output logic [2:0]              num_rn,
    output logic [2:0]              num_rd,
    output logic [2:0]              used,
    output logic [5:0]              inst_type,
    output logic [IMM_W-1:0]        sximm,
    output logic                    illegal,
    output logic                    is_halt
);

    logic [2:0] opcode;
    logic       asel, bsel, loads, write;
    logic [1:0] alu_op, shift;
    logic [2:0] writenum;

    assign opcode  = ir[15:13];
    assign is_halt = (opcode == OP_HALT);
    assign control = {opcode, pc, asel, bsel, loads, alu_op, shift, write, writenum};

    always_comb begin
        asel      = 1'b0;
        bsel      = 1'b0;
        loads     = 1'b0;
        write     = 1'b0;
        alu_op    = 2'b00;
        shift     = 2'b00;
        writenum  = 3'd0;
        num_rm    = 3'd0;
        num_rn    = 3'd0;
        num_rd    = 3'd0;
        used      = 3'b000;
        inst_type = 6'd0;
        sximm     = '0;
        illegal   = 1'b0;
        case (opcode)
            OP_MOV: begin
                bsel  = 1'b1;
                write = 1'b1;
                if (ir[12:11] == 2'b10) begin
                    asel     = 1'b1;
                    writenum = ir[10:8];
                    sximm    = {{(IMM_W-8){ir[7]}}, ir[7:0]};
                end else begin
                    writenum = ir[7:5];
                    shift    = ir[4:3];
                    num_rm   = ir[2:0];
                    used     = 3'b100;
                end
            end
            OP_ALU: begin
                alu_op = ir[12:11];
                shift  = ir[4:3];
                num_rm = ir[2:0];
                case (ir[12:11])
                    2'b01: begin
                        // CMP only updates flags, never a register
                        num_rn = ir[10:8];
                        loads  = 1'b1;
                        used   = 3'b110;
                    end
                    2'b11: begin
                        writenum = ir[7:5];
                        write    = 1'b1;
                        used     = 3'b100;
                    end
                    default: begin
                        num_rn   = ir[10:8];
                        writenum = ir[7:5];
                        write    = 1'b1;
                        used     = 3'b110;
                    end
                endcase
            end
            OP_STR: begin
                bsel                    = 1'b1;
                num_rm                  = ir[10:8];
                num_rd                  = ir[7:5];
                sximm                   = {{(IMM_W-5){ir[4]}}, ir[4:0]};
                used                    = 3'b101;
                inst_type[INST_STR_BIT] = 1'b1;
            end
            OP_LDR: begin
                bsel                    = 1'b1;
                num_rm                  = ir[10:8];
                write                   = 1'b1;
                writenum                = ir[7:5];
                sximm                   = {{(IMM_W-5){ir[4]}}, ir[4:0]};
                used                    = 3'b100;
                inst_type[INST_LDR_BIT] = 1'b1;
            end
            OP_ILL1, OP_ILL2: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage_hs.sv
// Decode pipeline stage with valid/ready handshakes, a one-entry skid buffer
// behind the output register, and a RUN/HALTED FSM driven by HALT and resume.
module decode_stage_hs
    import decode_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int IMM_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             ir_in,
    input  logic [PC_W-1:0]         pc_in,
    input  logic                    flush,
    input  logic                    resume,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ctrl_w(PC_W)-1:0] control_out,
    output logic [2:0]              num_rm,
    output logic [2:0]              num_rn,
    output logic [2:0]              num_rd,
    output logic [2:0]              used_rmrnrd,
    output logic [5:0]              inst_type,
    output logic [IMM_W-1:0]        sximm,
    output logic                    illegal,
    output logic                    halted
);

    localparam int CTRL_W = ctrl_w(PC_W);
    localparam int BW     = CTRL_W + 12 + 6 + IMM_W + 1;

    logic [CTRL_W-1:0] dec_control;
    logic [2:0]        dec_rm, dec_rn, dec_rd, dec_used;
    logic [5:0]        dec_inst_type;
    logic [IMM_W-1:0]  dec_sximm;
    logic              dec_illegal, dec_is_halt;
    logic [BW-1:0]     dec_bundle;

    state_e        state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic [BW-1:0] out_bundle_q, out_bundle_d;
    logic          skid_valid_q, skid_valid_d;
    logic [BW-1:0] skid_bundle_q, skid_bundle_d;
    logic          accept;

    decode_comb #(.PC_W(PC_W), .IMM_W(IMM_W)) u_decode (
        .ir        (ir_in),
        .pc        (pc_in),
        .control   (dec_control),
        .num_rm    (dec_rm),
        .num_rn    (dec_rn),
        .num_rd    (dec_rd),
        .used      (dec_used),
        .inst_type (dec_inst_type),
        .sximm     (dec_sximm),
        .illegal   (dec_illegal),
        .is_halt   (dec_is_halt)
    );

    assign dec_bundle = {dec_control, dec_rm, dec_rn, dec_rd, dec_used,
                         dec_inst_type, dec_sximm, dec_illegal};

    // Accepting only with an empty skid guarantees a free slot even under stall
    assign in_ready = rst_n && (state_q == ST_RUN) && !skid_valid_q && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_bundle_d  = out_bundle_q;
        skid_valid_d  = skid_valid_q;
        skid_bundle_d = skid_bundle_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            state_d      = ST_RUN;
        end else begin
            if (!out_valid_q || out_ready) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_bundle_d = skid_bundle_q;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    out_valid_d  = 1'b1;
                    out_bundle_d = dec_bundle;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_valid_d  = 1'b1;
                skid_bundle_d = dec_bundle;
            end
            if (state_q == ST_RUN && accept && dec_is_halt) begin
                state_d = ST_HALTED;
            end else if (state_q == ST_HALTED && resume) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            out_valid_q   <= 1'b0;
            out_bundle_q  <= '0;
            skid_valid_q  <= 1'b0;
            skid_bundle_q <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_bundle_q  <= out_bundle_d;
            skid_valid_q  <= skid_valid_d;
            skid_bundle_q <= skid_bundle_d;
        end
    end

    assign out_valid = out_valid_q;
    assign halted    = (state_q == ST_HALTED);
    assign {control_out, num_rm, num_rn, num_rd, used_rmrnrd,
            inst_type, sximm, illegal} = out_bundle_q;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Self-checking bench for decode_stage_hs: directed scenarios plus a random
// run against a queue-based reference model of the two-entry stage.
module tb_decode_stage_hs;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, resume, out_valid, out_ready;
    logic [15:0] ir_in;
    logic [7:0]  pc_in;
    logic [21:0] control_out;
    logic [2:0]  num_rm, num_rn, num_rd, used_rmrnrd;
    logic [5:0]  inst_type;
    logic [15:0] sximm;
    logic        illegal, halted;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [21:0] ctrl;
        logic [2:0]  rm;
        logic [2:0]  rn;
        logic [2:0]  rd;
        logic [2:0]  used;
        logic [5:0]  itype;
        logic [15:0] sximm;
        logic        ill;
    } exp_t;

    exp_t q[$];
    logic halted_m;

    always #5 clk = ~clk;

    decode_stage_hs #(.PC_W(8), .IMM_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ir_in(ir_in), .pc_in(pc_in), .flush(flush), .resume(resume),
        .out_valid(out_valid), .out_ready(out_ready), .control_out(control_out),
        .num_rm(num_rm), .num_rn(num_rn), .num_rd(num_rd),
        .used_rmrnrd(used_rmrnrd), .inst_type(inst_type), .sximm(sximm),
        .illegal(illegal), .halted(halted)
    );

    // Reference decode written straight from the instruction table
    function automatic exp_t ref_decode(input logic [15:0] ir, input logic [7:0] pc);
        exp_t e;
        logic [2:0] op;
        logic asel, bsel, loads, wr;
        logic [1:0] aluop, sh;
        logic [2:0] wn;
        e = '0; asel = 0; bsel = 0; loads = 0; wr = 0; aluop = 0; sh = 0; wn = 0;
        op = ir[15:13];
        if (op == 3'b110 && ir[12:11] == 2'b10) begin
            asel = 1; bsel = 1; wr = 1; wn = ir[10:8];
            e.sximm = {{8{ir[7]}}, ir[7:0]};
        end else if (op == 3'b110) begin
            bsel = 1; wr = 1; wn = ir[7:5]; sh = ir[4:3]; e.rm = ir[2:0]; e.used = 3'b100;
        end else if (op == 3'b101) begin
            aluop = ir[12:11]; sh = ir[4:3]; e.rm = ir[2:0];
            if (aluop == 2'b01) begin
                e.rn = ir[10:8]; loads = 1; e.used = 3'b110;
            end else if (aluop == 2'b11) begin
                wn = ir[7:5]; wr = 1; e.used = 3'b100;
            end else begin
                e.rn = ir[10:8]; wn = ir[7:5]; wr = 1; e.used = 3'b110;
            end
        end else if (op == 3'b100) begin
            bsel = 1; e.rm = ir[10:8]; e.rd = ir[7:5];
            e.sximm = {{11{ir[4]}}, ir[4:0]}; e.used = 3'b101; e.itype = 6'b000010;
        end else if (op == 3'b011) begin
            bsel = 1; e.rm = ir[10:8]; wr = 1; wn = ir[7:5];
            e.sximm = {{11{ir[4]}}, ir[4:0]}; e.used = 3'b100; e.itype = 6'b000001;
        end else if (op == 3'b001 || op == 3'b010) begin
            e.ill = 1;
        end
        e.ctrl = {op, pc, asel, bsel, loads, aluop, sh, wr, wn};
        return e;
    endfunction

    function automatic exp_t dut_bundle();
        return {control_out, num_rm, num_rn, num_rd, used_rmrnrd, inst_type, sximm, illegal};
    endfunction

    task automatic drive(input logic v, input logic [15:0] ir, input logic [7:0] pc,
                         input logic fl, input logic rs, input logic ordy);
        in_valid = v; ir_in = ir; pc_in = pc; flush = fl; resume = rs; out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(1, 16'hD485, 8'h10, 0, 0, 1);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        tick(); tick();
        drive(1, 16'hD485, 8'h10, 0, 0, 1);
        n_checks++;
        if ({out_valid, halted, illegal} !== 3'b000 || dut_bundle() !== exp_t'(0)) begin
            n_errors++;
            $display("FAIL reset_state got v=%b h=%b bundle=%h want v=0 h=0 bundle=0",
                     out_valid, halted, dut_bundle());
        end
        rst_n = 1;
        drive(0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_mov_imm();
        drive(1, 16'hD485, 8'h10, 0, 0, 1);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL mov_in_ready got=%b want=1", in_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 1);
        n_checks++;
        if (out_valid !== 1'b1 || control_out[2:0] !== 3'd4 || sximm !== 16'hFF85 ||
            control_out[10] !== 1'b1 || control_out[9] !== 1'b1 || control_out[3] !== 1'b1 ||
            control_out[18:11] !== 8'h10) begin
            n_errors++;
            $display("FAIL mov_imm_fields got v=%b ctrl=%h sximm=%h want v=1 wn=4 sximm=ff85 asel/bsel/write=1 pc=10",
                     out_valid, control_out, sximm);
        end
        n_checks++;
        if (dut_bundle() !== ref_decode(16'hD485, 8'h10)) begin
            n_errors++;
            $display("FAIL mov_imm_bundle got=%h want=%h", dut_bundle(), ref_decode(16'hD485, 8'h10));
        end
        $display("txn mov_imm ir=d485 bundle=%h", dut_bundle());
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1, 16'hA1A9, 8'h20, 0, 0, 1);
        tick();
        drive(1, 16'h6253, 8'h21, 0, 0, 1);
        n_checks++;
        if (out_valid !== 1'b1 || num_rn !== 3'd1 || num_rm !== 3'd1 || control_out[2:0] !== 3'd5 ||
            control_out[5:4] !== 2'b01 || used_rmrnrd !== 3'b110) begin
            n_errors++;
            $display("FAIL b2b_add got v=%b rn=%0d rm=%0d ctrl=%h used=%b want v=1 rn=1 rm=1 wn=5 shift=01 used=110",
                     out_valid, num_rn, num_rm, control_out, used_rmrnrd);
        end
        $display("txn b2b_add ir=a1a9 bundle=%h", dut_bundle());
        tick();
        drive(0, 0, 0, 0, 0, 1);
        n_checks++;
        if (out_valid !== 1'b1 || num_rm !== 3'd2 || control_out[2:0] !== 3'd2 ||
            sximm !== 16'hFFF3 || inst_type !== 6'b000001) begin
            n_errors++;
            $display("FAIL b2b_ldr got v=%b rm=%0d ctrl=%h sximm=%h itype=%b want v=1 rm=2 wn=2 sximm=fff3 itype=000001",
                     out_valid, num_rm, control_out, sximm, inst_type);
        end
        $display("txn b2b_ldr ir=6253 bundle=%h", dut_bundle());
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL b2b_drain got=%b want=0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        exp_t first, second;
        first  = ref_decode(16'hB0E8, 8'h30);
        second = ref_decode(16'h8A7F, 8'h31);
        drive(1, 16'hB0E8, 8'h30, 0, 0, 0);
        tick();
        drive(1, 16'h8A7F, 8'h31, 0, 0, 0);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || dut_bundle() !== first) begin
            n_errors++;
            $display("FAIL bp_second_slot got rdy=%b v=%b bundle=%h want rdy=1 v=1 bundle=%h",
                     in_ready, out_valid, dut_bundle(), first);
        end
        tick();
        drive(1, 16'hC0A3, 8'h32, 0, 0, 0);
        n_checks++;
        if (in_ready !== 1'b0 || dut_bundle() !== first) begin
            n_errors++;
            $display("FAIL bp_full got rdy=%b bundle=%h want rdy=0 bundle=%h", in_ready, dut_bundle(), first);
        end
        tick();
        drive(0, 0, 0, 0, 0, 1);
        n_checks++;
        if (out_valid !== 1'b1 || dut_bundle() !== first) begin
            n_errors++; $display("FAIL bp_release_1 got v=%b bundle=%h want %h", out_valid, dut_bundle(), first);
        end
        $display("txn bp_first bundle=%h", dut_bundle());
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || dut_bundle() !== second) begin
            n_errors++; $display("FAIL bp_release_2 got v=%b bundle=%h want %h", out_valid, dut_bundle(), second);
        end
        $display("txn bp_second bundle=%h", dut_bundle());
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL bp_third_dropped got v=%b want=0", out_valid);
        end
    endtask

    task automatic test_halt();
        drive(1, 16'hE000, 8'h40, 0, 0, 1);
        tick();
        drive(1, 16'hA1A9, 8'h41, 0, 0, 1);
        n_checks++;
        if (out_valid !== 1'b1 || dut_bundle() !== ref_decode(16'hE000, 8'h40) ||
            halted !== 1'b1 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_emit got v=%b h=%b rdy=%b bundle=%h want v=1 h=1 rdy=0 bundle=%h",
                     out_valid, halted, in_ready, dut_bundle(), ref_decode(16'hE000, 8'h40));
        end
        $display("txn halt bundle=%h", dut_bundle());
        tick();
        drive(1, 16'hA1A9, 8'h41, 0, 1, 1);
        n_checks++;
        if (out_valid !== 1'b0 || halted !== 1'b1 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_hold got v=%b h=%b rdy=%b want v=0 h=1 rdy=0", out_valid, halted, in_ready);
        end
        tick();
        drive(1, 16'hA1A9, 8'h41, 0, 0, 1);
        n_checks++;
        if (halted !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL halt_resume got h=%b rdy=%b want h=0 rdy=1", halted, in_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 1);
        n_checks++;
        if (out_valid !== 1'b1 || dut_bundle() !== ref_decode(16'hA1A9, 8'h41)) begin
            n_errors++;
            $display("FAIL halt_after_resume got v=%b bundle=%h want v=1 bundle=%h",
                     out_valid, dut_bundle(), ref_decode(16'hA1A9, 8'h41));
        end
        tick();
    endtask

    task automatic test_illegal_flush();
        logic [15:0] ill_ir;
        ill_ir = {3'b001, 13'($urandom)};
        drive(1, ill_ir, 8'h50, 0, 0, 0);
        tick();
        drive(1, 16'h6253, 8'h51, 0, 0, 0);
        n_checks++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || control_out[3] !== 1'b0 ||
            dut_bundle() !== ref_decode(ill_ir, 8'h50)) begin
            n_errors++;
            $display("FAIL illegal got v=%b ill=%b write=%b bundle=%h want v=1 ill=1 write=0 bundle=%h",
                     out_valid, illegal, control_out[3], dut_bundle(), ref_decode(ill_ir, 8'h50));
        end
        $display("txn illegal ir=%h bundle=%h", ill_ir, dut_bundle());
        tick();
        drive(1, 16'hD485, 8'h52, 1, 0, 1);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++; $display("FAIL flush_in_ready got=%b want=0", in_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL flush_clear got v=%b want=0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL flush_empty got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        logic        v, fl, rs, ordy, exp_rdy, acc;
        logic [15:0] ir;
        logic [7:0]  pc;
        q.delete();
        halted_m = 0;
        for (int i = 0; i < 600; i++) begin
            v    = ($urandom_range(0, 9) < 7);
            ir   = 16'($urandom);
            pc   = 8'($urandom);
            fl   = ($urandom_range(0, 99) < 3);
            rs   = ($urandom_range(0, 9) == 0);
            ordy = ($urandom_range(0, 9) < 6);
            drive(v, ir, pc, fl, rs, ordy);
            exp_rdy = !halted_m && (q.size() < 2) && !fl;
            acc = v && exp_rdy;
            n_checks++;
            if (in_ready !== exp_rdy || out_valid !== (q.size() > 0) || halted !== halted_m) begin
                n_errors++;
                $display("FAIL rand_ctrl cyc=%0d got rdy=%b v=%b h=%b want rdy=%b v=%b h=%b",
                         i, in_ready, out_valid, halted, exp_rdy, q.size() > 0, halted_m);
            end
            if (q.size() > 0) begin
                n_checks++;
                if (dut_bundle() !== q[0]) begin
                    n_errors++;
                    $display("FAIL rand_bundle cyc=%0d got=%h want=%h", i, dut_bundle(), q[0]);
                end
                if (ordy) $display("txn rand cyc=%0d bundle=%h", i, dut_bundle());
            end
            if (fl) begin
                q.delete();
                halted_m = 0;
            end else begin
                if (q.size() > 0 && ordy) void'(q.pop_front());
                if (acc) q.push_back(ref_decode(ir, pc));
                if (!halted_m && acc && ir[15:13] == 3'b111) halted_m = 1;
                else if (halted_m && rs) halted_m = 0;
            end
            tick();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mov_imm();
        test_back_to_back();
        test_backpressure();
        test_halt();
        test_illegal_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
